// File: rtl/dw_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dw_conv_arbiter
// Brief    : Packet-granular round-robin arbiter feeding one shared data-width
//            converter through a single registered output stage.
// Revision : 1.0
// ============================================================================
module dw_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 512,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]    req_last_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [DW-1:0]         conv_data_o,
  output logic                  conv_last_o,
  output logic [IDW-1:0]        conv_id_o,
  output logic                  conv_valid_o,
  input  logic                  conv_ready_i,
  output logic                  busy_o
);

  localparam logic [0:0]   c_IDLE   = 1'b0;
  localparam logic [0:0]   c_LOCKED = 1'b1;
  localparam logic [IDW:0] c_NUM    = (IDW+1)'(NUM_REQ);

  logic [0:0]         r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_owner;
  logic [DW-1:0]      r_data;
  logic               r_last;
  logic [IDW-1:0]     r_id;
  logic               r_valid;

  logic               w_found;
  logic [IDW-1:0]     w_pick;
  logic [IDW-1:0]     w_cand;
  logic [IDW-1:0]     w_grant;
  logic               w_gvalid;
  logic               w_can_load;
  logic               w_accept;
  logic               w_last;
  logic [DW-1:0]      w_data;
  logic [IDW-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0] w_ready;

  // Index arithmetic modulo NUM_REQ, valid for non-power-of-two counts.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input logic [IDW:0]   off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= c_NUM) sum = sum - c_NUM;
    return sum[IDW-1:0];
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = wrap_add(r_ptr, (IDW+1)'(k));
      if (!w_found && req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // The grant is only committed (LOCKED) once a non-last beat is accepted.
  assign w_grant    = (r_state == c_LOCKED) ? r_owner : w_pick;
  assign w_gvalid   = (r_state == c_LOCKED) ? req_valid_i[r_owner] : w_found;
  assign w_can_load = !r_valid || conv_ready_i;
  assign w_accept   = w_gvalid && w_can_load;
  assign w_last     = req_last_i[w_grant];
  assign w_next_ptr = wrap_add(w_grant, (IDW+1)'(1));

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDW'(i)) w_data = req_data_i[i*DW +: DW];
    end
  end

  always_comb begin
    w_ready = '0;
    if (!rst_i && ((r_state == c_LOCKED) || w_found)) w_ready[w_grant] = w_can_load;
  end

  assign req_ready_o = w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= w_data;
        r_last  <= w_last;
        r_id    <= w_grant;
        r_valid <= 1'b1;
      end else if (conv_ready_i) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (w_last) begin
              r_ptr <= w_next_ptr;
            end else begin
              r_state <= c_LOCKED;
              r_owner <= w_grant;
            end
          end
        end
        c_LOCKED: begin
          if (w_accept && w_last) begin
            r_state <= c_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign conv_data_o  = r_data;
  assign conv_last_o  = r_last;
  assign conv_id_o    = r_id;
  assign conv_valid_o = r_valid;
  assign busy_o       = (r_state == c_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_dw_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dw_conv_arbiter
// Brief    : Directed self-checking bench for dw_conv_arbiter (4 requesters).
// Revision : 1.0
// ============================================================================
module tb_dw_conv_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_last, req_valid, req_ready;
  logic [W-1:0]  conv_data;
  logic          conv_last, conv_valid, conv_ready, busy;
  logic [1:0]    conv_id;

  dw_conv_arbiter #(.NUM_REQ(NR), .DW(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_data_i(req_data), .req_last_i(req_last),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .conv_data_o(conv_data), .conv_last_o(conv_last), .conv_id_o(conv_id),
    .conv_valid_o(conv_valid), .conv_ready_i(conv_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Per-requester beat sources and captured output beats
  logic [W-1:0] mem_d [NR][16];
  logic         mem_l [NR][16];
  int           rd [NR];
  int           wr [NR];
  logic         hold [NR];
  logic [W-1:0] cap_d [32];
  logic [1:0]   cap_id [32];
  logic         cap_l [32];
  int           cap_cyc [32];
  logic [W-1:0] exp_d [16];
  logic [1:0]   exp_id [16];
  logic         exp_l [16];
  int           n_exp, n_out, cyc;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    if (wr[r] < 16) begin
      mem_d[r][wr[r]] = d;
      mem_l[r][wr[r]] = l;
      wr[r]++;
    end
  endtask

  task automatic drive_all();
    for (int i = 0; i < NR; i++) begin
      if (rd[i] < wr[i]) begin
        req_data[i*W +: W] = mem_d[i][rd[i]];
        req_last[i]        = mem_l[i][rd[i]];
        req_valid[i]       = !hold[i];
      end else begin
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
        req_valid[i]       = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic hs [NR];
    @(negedge clk);
    if (conv_valid && conv_ready && n_out < 32) begin
      cap_d[n_out]   = conv_data;
      cap_id[n_out]  = conv_id;
      cap_l[n_out]   = conv_last;
      cap_cyc[n_out] = cyc;
      n_out++;
    end
    for (int i = 0; i < NR; i++) hs[i] = req_valid[i] && req_ready[i];
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) rd[i]++;
    drive_all();
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (n_out < n && k < budget) begin
      step();
      k++;
    end
    check_val({tag, "_count"}, 64'(n_out), 64'(n));
  endtask

  task automatic set_exp(input int k, input logic [1:0] id, input logic [W-1:0] d, input logic l);
    exp_id[k] = id;
    exp_d[k]  = d;
    exp_l[k]  = l;
    if (k + 1 > n_exp) n_exp = k + 1;
  endtask

  task automatic check_capture(input string tag, input bit chk_gap);
    for (int k = 0; k < n_exp; k++) begin
      check_val($sformatf("%s_id%0d", tag, k), 64'(cap_id[k]), 64'(exp_id[k]));
      check_val($sformatf("%s_data%0d", tag, k), 64'(cap_d[k]), 64'(exp_d[k]));
      check_val($sformatf("%s_last%0d", tag, k), 64'(cap_l[k]), 64'(exp_l[k]));
      if (chk_gap && k > 0)
        check_val($sformatf("%s_gap%0d", tag, k), 64'(cap_cyc[k] - cap_cyc[k-1]), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) begin
      rd[i] = 0; wr[i] = 0; hold[i] = 1'b0;
    end
    n_out = 0; n_exp = 0; cyc = 0;
    conv_ready = 1'b1;
    drive_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; conv_ready = 1'b1;
    req_data = '0; req_last = '0; req_valid = 4'hF;
    n_out = 0; n_exp = 0; cyc = 0;
    #2;
    // Reset state with every requester asserting valid
    check_val("rst_ready", 64'(req_ready), 64'h0);
    check_val("rst_valid", 64'(conv_valid), 64'h0);
    check_val("rst_data", 64'(conv_data), 64'h0);
    check_val("rst_last", 64'(conv_last), 64'h0);
    check_val("rst_id", 64'(conv_id), 64'h0);
    check_val("rst_busy", 64'(busy), 64'h0);
    do_reset();

    // Single requester, 3-beat packet
    push(0, 16'h0001, 1'b0); push(0, 16'h0002, 1'b0); push(0, 16'h0003, 1'b1);
    drive_all(); #1;
    check_val("t2_ready", 64'(req_ready), 64'h1);
    step();
    check_val("t2_b0_valid", 64'(conv_valid), 64'h1);
    check_val("t2_b0_data", 64'(conv_data), 64'h0001);
    check_val("t2_b0_last", 64'(conv_last), 64'h0);
    check_val("t2_b0_busy", 64'(busy), 64'h1);
    step();
    check_val("t2_b1_data", 64'(conv_data), 64'h0002);
    check_val("t2_b1_busy", 64'(busy), 64'h1);
    step();
    check_val("t2_b2_data", 64'(conv_data), 64'h0003);
    check_val("t2_b2_last", 64'(conv_last), 64'h1);
    check_val("t2_b2_id", 64'(conv_id), 64'h0);
    check_val("t2_b2_busy", 64'(busy), 64'h0);
    step();
    check_val("t2_drain_valid", 64'(conv_valid), 64'h0);

    // All four requesters, 2-beat packets; requester 0 has two packets
    do_reset();
    push(0, 16'h0011, 1'b0); push(0, 16'h0012, 1'b1);
    push(0, 16'h0013, 1'b0); push(0, 16'h0014, 1'b1);
    push(1, 16'h0121, 1'b0); push(1, 16'h0122, 1'b1);
    push(2, 16'h0231, 1'b0); push(2, 16'h0232, 1'b1);
    push(3, 16'h0341, 1'b0); push(3, 16'h0342, 1'b1);
    drive_all(); #1;
    run_until(10, 40, "t3");
    set_exp(0, 2'd0, 16'h0011, 1'b0); set_exp(1, 2'd0, 16'h0012, 1'b1);
    set_exp(2, 2'd1, 16'h0121, 1'b0); set_exp(3, 2'd1, 16'h0122, 1'b1);
    set_exp(4, 2'd2, 16'h0231, 1'b0); set_exp(5, 2'd2, 16'h0232, 1'b1);
    set_exp(6, 2'd3, 16'h0341, 1'b0); set_exp(7, 2'd3, 16'h0342, 1'b1);
    set_exp(8, 2'd0, 16'h0013, 1'b0); set_exp(9, 2'd0, 16'h0014, 1'b1);
    check_capture("t3", 1'b1);

    // Requester 2 arrives while requester 1 is mid-packet
    do_reset();
    push(1, 16'h0141, 1'b0); push(1, 16'h0142, 1'b0);
    push(1, 16'h0143, 1'b0); push(1, 16'h0144, 1'b1);
    drive_all(); #1;
    step(); step();
    push(2, 16'h0251, 1'b1);
    drive_all(); #1;
    check_val("t4_ready_locked", 64'(req_ready), 64'h2);
    step();
    check_val("t4_ready_locked2", 64'(req_ready), 64'h2);
    run_until(5, 20, "t4");
    set_exp(0, 2'd1, 16'h0141, 1'b0); set_exp(1, 2'd1, 16'h0142, 1'b0);
    set_exp(2, 2'd1, 16'h0143, 1'b0); set_exp(3, 2'd1, 16'h0144, 1'b1);
    set_exp(4, 2'd2, 16'h0251, 1'b1);
    check_capture("t4", 1'b1);

    // Converter stall for 5 cycles
    do_reset();
    push(0, 16'h0501, 1'b0); push(0, 16'h0502, 1'b0); push(0, 16'h0503, 1'b1);
    drive_all(); #1;
    step();
    conv_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val($sformatf("t5_stall_valid%0d", k), 64'(conv_valid), 64'h1);
      check_val($sformatf("t5_stall_data%0d", k), 64'(conv_data), 64'h0501);
      check_val($sformatf("t5_stall_ready%0d", k), 64'(req_ready), 64'h0);
    end
    check_val("t5_stall_last", 64'(conv_last), 64'h0);
    check_val("t5_stall_id", 64'(conv_id), 64'h0);
    conv_ready = 1'b1; #1;
    run_until(3, 20, "t5");
    set_exp(0, 2'd0, 16'h0501, 1'b0); set_exp(1, 2'd0, 16'h0502, 1'b0);
    set_exp(2, 2'd0, 16'h0503, 1'b1);
    check_capture("t5", 1'b1);
    step();
    check_val("t5_no_dup", 64'(n_out), 64'd3);

    // Owner drops valid mid-packet while requester 3 waits
    do_reset();
    push(0, 16'h0601, 1'b0); push(0, 16'h0602, 1'b0);
    push(0, 16'h0603, 1'b0); push(0, 16'h0604, 1'b1);
    push(3, 16'h0631, 1'b1);
    drive_all(); #1;
    step(); step();
    hold[0] = 1'b1;
    drive_all(); #1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val($sformatf("t6_hold_valid%0d", k), 64'(conv_valid), 64'h0);
      check_val($sformatf("t6_hold_busy%0d", k), 64'(busy), 64'h1);
      check_val($sformatf("t6_hold_ready%0d", k), 64'(req_ready), 64'h1);
    end
    hold[0] = 1'b0;
    drive_all(); #1;
    run_until(5, 20, "t6");
    set_exp(0, 2'd0, 16'h0601, 1'b0); set_exp(1, 2'd0, 16'h0602, 1'b0);
    set_exp(2, 2'd0, 16'h0603, 1'b0); set_exp(3, 2'd0, 16'h0604, 1'b1);
    set_exp(4, 2'd3, 16'h0631, 1'b1);
    check_capture("t6", 1'b0);

    // Asynchronous reset mid-packet; pointer returns to 0
    do_reset();
    push(2, 16'h0721, 1'b1);
    drive_all(); #1;
    run_until(1, 10, "t7_pre");
    push(3, 16'h0731, 1'b0); push(3, 16'h0732, 1'b0);
    push(3, 16'h0733, 1'b0); push(3, 16'h0734, 1'b1);
    drive_all(); #1;
    step(); step();
    check_val("t7_busy_before", 64'(busy), 64'h1);
    rst = 1'b1; #1;
    check_val("t7_async_valid", 64'(conv_valid), 64'h0);
    check_val("t7_async_data", 64'(conv_data), 64'h0);
    check_val("t7_async_id", 64'(conv_id), 64'h0);
    check_val("t7_async_last", 64'(conv_last), 64'h0);
    check_val("t7_async_busy", 64'(busy), 64'h0);
    check_val("t7_async_ready", 64'(req_ready), 64'h0);
    do_reset();
    push(2, 16'h0741, 1'b1); push(3, 16'h0751, 1'b1);
    drive_all(); #1;
    check_val("t7_ptr_ready", 64'(req_ready), 64'h4);
    run_until(2, 10, "t7");
    set_exp(0, 2'd2, 16'h0741, 1'b1); set_exp(1, 2'd3, 16'h0751, 1'b1);
    check_capture("t7", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
